// File: rtl/onchip_memory_dp.sv
// True dual-port on-chip RAM with two Avalon-MM slaves, pipelined reads,
// optional post-reset zero fill and s1-priority merging of same-address writes.

module onchip_memory_dp_rdpipe #(
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clken,
    input  logic              rd_acc,
    input  logic              rd_oor,
    input  logic [DATA_W-1:0] ram_q,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid
);
    // vld_pipe[0] marks ram_q as holding the word for an accepted read.
    logic [READ_LATENCY:0]             vld_pipe;
    logic                              oor_q;
    logic [READ_LATENCY:1][DATA_W-1:0] dat;
    logic [DATA_W-1:0]                 ram_sel;

    assign ram_sel = oor_q ? '0 : ram_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            oor_q    <= 1'b0;
            dat      <= '0;
        end else if (clken) begin
            vld_pipe <= {vld_pipe[READ_LATENCY-1:0], rd_acc};
            oor_q    <= rd_oor;
            if (vld_pipe[0])
                dat[1] <= ram_sel;
            for (int k = 2; k <= READ_LATENCY; k++)
                if (vld_pipe[k-1])
                    dat[k] <= dat[k-1];
        end
    end

    assign readdata      = dat[READ_LATENCY];
    assign readdatavalid = vld_pipe[READ_LATENCY];
endmodule

module onchip_memory_dp #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 15,
    parameter int DEPTH        = 32000,
    parameter int READ_LATENCY = 1,
    parameter int INIT_ZERO    = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clken,
    input  logic [ADDR_W-1:0]   s1_address,
    input  logic                s1_chipselect,
    input  logic                s1_read,
    input  logic                s1_write,
    input  logic [DATA_W-1:0]   s1_writedata,
    input  logic [DATA_W/8-1:0] s1_byteenable,
    output logic [DATA_W-1:0]   s1_readdata,
    output logic                s1_readdatavalid,
    output logic                s1_waitrequest,
    input  logic [ADDR_W-1:0]   s2_address,
    input  logic                s2_chipselect,
    input  logic                s2_read,
    input  logic                s2_write,
    input  logic [DATA_W-1:0]   s2_writedata,
    input  logic [DATA_W/8-1:0] s2_byteenable,
    output logic [DATA_W-1:0]   s2_readdata,
    output logic                s2_readdatavalid,
    output logic                s2_waitrequest,
    output logic                init_done,
    output logic                collision
);
    localparam int BE_W   = DATA_W / 8;
    localparam int NP     = 2;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [MEM_AW-1:0] LAST_WORD = MEM_AW'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_CMP = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {ST_RESET, ST_INIT, ST_RUN} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              cs;
        logic              rd;
        logic              wr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } req_t;

    req_t [NP-1:0]             req;
    state_t                    state, state_nxt;
    logic [MEM_AW-1:0]         fill_ptr;
    logic                      waitreq, fill_we, run;
    logic [NP-1:0]             in_range, acc, wr_en, rd_acc;
    logic [NP-1:0][MEM_AW-1:0] widx;
    logic [NP-1:0][DATA_W-1:0] ram_q, rdata;
    logic [NP-1:0]             rvalid;
    logic                      coll_q;
    logic [DATA_W-1:0]         mem [DEPTH];

    assign req[0] = '{s1_address, s1_chipselect, s1_read, s1_write, s1_writedata, s1_byteenable};
    assign req[1] = '{s2_address, s2_chipselect, s2_read, s2_write, s2_writedata, s2_byteenable};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_RESET;
            fill_ptr <= '0;
        end else if (clken) begin
            state <= state_nxt;
            if (state == ST_INIT)
                fill_ptr <= fill_ptr + MEM_AW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RESET: state_nxt = (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
            ST_INIT:  state_nxt = (fill_ptr == LAST_WORD) ? ST_RUN : ST_INIT;
            ST_RUN:   state_nxt = ST_RUN;
            default:  state_nxt = ST_RESET;
        endcase
    end

    always_comb begin
        run     = reset_n && (state == ST_RUN);
        waitreq = !(run && clken);
        fill_we = reset_n && (state == ST_INIT);
    end

    // A combined read+write performs only the write.
    for (genvar p = 0; p < NP; p++) begin : g_port
        assign in_range[p] = {1'b0, req[p].addr} < DEPTH_CMP;
        assign acc[p]      = req[p].cs & (req[p].rd | req[p].wr) & ~waitreq;
        assign wr_en[p]    = acc[p] & req[p].wr & in_range[p];
        assign rd_acc[p]   = acc[p] & ~req[p].wr;
        assign widx[p]     = req[p].addr[MEM_AW-1:0];

        onchip_memory_dp_rdpipe #(
            .DATA_W       (DATA_W),
            .READ_LATENCY (READ_LATENCY)
        ) u_rdpipe (
            .clk           (clk),
            .reset_n       (reset_n),
            .clken         (clken),
            .rd_acc        (rd_acc[p]),
            .rd_oor        (~in_range[p]),
            .ram_q         (ram_q[p]),
            .readdata      (rdata[p]),
            .readdatavalid (rvalid[p])
        );
    end

    // Registered read sees pre-write contents, giving old-data on cross-port RDW.
    always_ff @(posedge clk) begin
        if (clken)
            for (int p = 0; p < NP; p++)
                ram_q[p] <= mem[widx[p]];
    end

    // s2 lanes are written first so s1 overrides on lanes both ports enable.
    always_ff @(posedge clk) begin
        if (clken) begin
            if (fill_we)
                mem[fill_ptr] <= '0;
            for (int p = NP - 1; p >= 0; p--)
                if (wr_en[p])
                    for (int b = 0; b < BE_W; b++)
                        if (req[p].be[b])
                            mem[widx[p]][b*8 +: 8] <= req[p].wdata[b*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            coll_q <= 1'b0;
        else
            coll_q <= wr_en[0] & wr_en[1] & (req[0].addr == req[1].addr);
    end

    assign s1_readdata      = reset_n ? rdata[0] : '0;
    assign s2_readdata      = reset_n ? rdata[1] : '0;
    assign s1_readdatavalid = reset_n & rvalid[0];
    assign s2_readdatavalid = reset_n & rvalid[1];
    assign s1_waitrequest   = waitreq;
    assign s2_waitrequest   = waitreq;
    assign init_done        = run;
    assign collision        = reset_n & coll_q;
endmodule

// File: tb/tb_onchip_memory_dp.sv
// Directed bench for onchip_memory_dp: zero fill, byte enables, collisions,
// cross-port read-during-write, clken stalls, reset mid-fill and out-of-range access.

module tb_onchip_memory_dp;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          clken = 1'b1;
    logic [AW-1:0] s1_address = '0, s2_address = '0;
    logic          s1_chipselect = 1'b0, s2_chipselect = 1'b0;
    logic          s1_read = 1'b0, s2_read = 1'b0;
    logic          s1_write = 1'b0, s2_write = 1'b0;
    logic [DW-1:0] s1_writedata = '0, s2_writedata = '0;
    logic [3:0]    s1_byteenable = '0, s2_byteenable = '0;
    logic [DW-1:0] s1_readdata, s2_readdata;
    logic          s1_readdatavalid, s2_readdatavalid;
    logic          s1_waitrequest, s2_waitrequest;
    logic          init_done, collision;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [31:0]   exp_mem [DEPTH];

    always #5 clk = ~clk;

    onchip_memory_dp #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .READ_LATENCY(1), .INIT_ZERO(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .clken(clken),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
        .s1_write(s1_write), .s1_writedata(s1_writedata), .s1_byteenable(s1_byteenable),
        .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
        .s1_waitrequest(s1_waitrequest),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
        .s2_write(s2_write), .s2_writedata(s2_writedata), .s2_byteenable(s2_byteenable),
        .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid),
        .s2_waitrequest(s2_waitrequest),
        .init_done(init_done), .collision(collision)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s1_chipselect = 0; s1_read = 0; s1_write = 0;
        s2_chipselect = 0; s2_read = 0; s2_write = 0;
    endtask

    task automatic wr(input int port, input logic [AW-1:0] a, input logic [31:0] d,
                      input logic [3:0] be);
        if (port == 1) begin
            s1_chipselect = 1; s1_write = 1; s1_address = a; s1_writedata = d; s1_byteenable = be;
        end else begin
            s2_chipselect = 1; s2_write = 1; s2_address = a; s2_writedata = d; s2_byteenable = be;
        end
        tick();
        idle();
        if (a < DEPTH)
            for (int b = 0; b < 4; b++)
                if (be[b]) exp_mem[a[3:0]][b*8 +: 8] = d[b*8 +: 8];
    endtask

    task automatic rd(input int port, input logic [AW-1:0] a, input logic [31:0] exp,
                      input string tag);
        if (port == 1) begin
            s1_chipselect = 1; s1_read = 1; s1_address = a;
        end else begin
            s2_chipselect = 1; s2_read = 1; s2_address = a;
        end
        tick();
        idle();
        chk({tag, "_early"}, (port == 1) ? s1_readdatavalid : s2_readdatavalid, 0);
        tick();
        chk({tag, "_vld"}, (port == 1) ? s1_readdatavalid : s2_readdatavalid, 1);
        chk({tag, "_dat"}, (port == 1) ? s1_readdata : s2_readdata, exp);
    endtask

    task automatic wait_init(input string tag);
        int busy;
        busy = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (!init_done && s1_waitrequest && s2_waitrequest) busy++;
        end
        chk({tag, "_busy16"}, busy, 16);
        tick();
        chk({tag, "_done"}, init_done, 1);
        chk({tag, "_wreq"}, s1_waitrequest, 0);
    endtask

    initial begin
        logic [31:0] q[$];
        int k;
        logic accd;

        for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'h0;

        tick(); tick();
        chk("rst_wreq1", s1_waitrequest, 1);
        chk("rst_wreq2", s2_waitrequest, 1);
        chk("rst_done", init_done, 0);
        chk("rst_vld1", s1_readdatavalid, 0);
        chk("rst_dat1", s1_readdata, 0);
        chk("rst_coll", collision, 0);

        reset_n = 1;
        wait_init("init");
        for (int a = 0; a < DEPTH; a++) rd(1, AW'(a), 32'h0, "init_rd");

        wr(1, 5, 32'h11223344, 4'b1111);
        wr(2, 5, 32'hAABBCCDD, 4'b0101);
        rd(1, 5, 32'h11BB33DD, "be_rd");

        s1_chipselect = 1; s1_write = 1; s1_address = 7; s1_writedata = 32'hAAAAAAAA; s1_byteenable = 4'b0011;
        s2_chipselect = 1; s2_write = 1; s2_address = 7; s2_writedata = 32'h55555555; s2_byteenable = 4'b1111;
        tick();
        idle();
        chk("coll_pulse", collision, 1);
        tick();
        chk("coll_clear", collision, 0);
        exp_mem[7] = 32'h5555AAAA;
        rd(1, 7, 32'h5555AAAA, "coll_rd");

        s1_chipselect = 1; s1_write = 1; s1_address = 8; s1_writedata = 32'h12345678; s1_byteenable = 4'b1111;
        s2_chipselect = 1; s2_write = 1; s2_address = 9; s2_writedata = 32'h9ABCDEF0; s2_byteenable = 4'b1111;
        tick();
        idle();
        chk("nocoll", collision, 0);
        exp_mem[8] = 32'h12345678;
        exp_mem[9] = 32'h9ABCDEF0;
        rd(2, 9, 32'h9ABCDEF0, "dual_rd");

        s1_chipselect = 1; s1_write = 1; s1_address = 3; s1_writedata = 32'hDEADBEEF; s1_byteenable = 4'b1111;
        s2_chipselect = 1; s2_read = 1; s2_address = 3;
        tick();
        idle();
        tick();
        chk("rdw_vld", s2_readdatavalid, 1);
        chk("rdw_old", s2_readdata, 32'h0);
        exp_mem[3] = 32'hDEADBEEF;
        rd(2, 3, 32'hDEADBEEF, "rdw_new");

        for (int a = 0; a < 8; a++) wr(1, AW'(a), 32'hA0000000 | 32'(a), 4'b1111);
        clken = 0;
        #1;
        chk("clken_wreq", s2_waitrequest, 1);
        clken = 1;
        k = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            clken = !(cyc >= 4 && cyc < 7);
            if (k < 8) begin
                s1_chipselect = 1; s1_read = 1; s1_address = AW'(k);
            end else idle();
            #1;
            if (clken && s1_readdatavalid) q.push_back(s1_readdata);
            accd = s1_chipselect && s1_read && !s1_waitrequest;
            @(posedge clk);
            #1;
            if (accd) k++;
        end
        clken = 1;
        idle();
        chk("stream_issued", k, 8);
        chk("stream_count", q.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < q.size()) chk("stream_dat", q[i], exp_mem[i]);

        rd(1, 20, 32'h0, "oor_rd");
        wr(2, 21, 32'hFFFFFFFF, 4'b1111);
        rd(2, 21, 32'h0, "oor_rd2");
        for (int a = 0; a < DEPTH; a++) rd(1, AW'(a), exp_mem[a], "oor_keep");

        reset_n = 0;
        tick();
        reset_n = 1;
        for (int i = 0; i < 9; i++) tick();
        reset_n = 0;
        tick();
        chk("midfill_rst_done", init_done, 0);
        reset_n = 1;
        wait_init("refill");
        for (int a = 0; a < DEPTH; a++) rd(2, AW'(a), 32'h0, "refill_rd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
